// File: rtl/lock_pkg.sv
// Shared types and helpers for the electronics_lock_gen code lock.
package lock_pkg;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2,
    PROG     = 2'd3
  } lock_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    D0     = 2'd1,
    D1     = 2'd2,
    CANCEL = 2'd3
  } btn_ev_t;

  function automatic btn_ev_t decode_btn(input logic b0, input logic b1);
    btn_ev_t ev;
    case ({b1, b0})
      2'b01:   ev = D0;
      2'b10:   ev = D1;
      2'b11:   ev = CANCEL;
      default: ev = NONE;
    endcase
    return ev;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock hold and the lockout hold.
module lock_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load takes priority over counting; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (en_i && (cnt_q != {WIDTH{1'b0}})) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire fires during the last held cycle so the owner leaves on that edge.
  assign expire_o = en_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/electronics_lock_gen.sv
// Whole-word code lock with unlock hold, failure lockout and, when
// LOCK_PROGRAM_EN is defined, code reprogramming while unlocked.
module electronics_lock_gen
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 5'b01011,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           b0,
  input  logic                           b1,
  output logic                           unlock,
  output logic                           lockout,
  output logic                           err,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);

  localparam int POS_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W  = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

  lock_state_t       state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              mis_q, mis_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              err_q, err_d;
  logic              unlock_q, unlock_d;
  logic              lockout_q, lockout_d;

  btn_ev_t           ev_s;
  logic              digit_s;
  logic              bad_s;
  logic [FAIL_W-1:0] fail_inc_s;
  logic [CODE_LEN-1:0] code_s;

  logic              tmr_load_s;
  logic [TMR_W-1:0]  tmr_val_s;
  logic              tmr_en_s;
  logic              tmr_expire_s;

`ifdef LOCK_PROGRAM_EN
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [CODE_LEN-1:0] stage_q, stage_d;
  logic [CODE_LEN-1:0] stage_shift_s;

  assign code_s        = code_q;
  assign stage_shift_s = CODE_LEN'({stage_q, digit_s});
`else
  assign code_s = DEFAULT_CODE;
`endif

  assign ev_s       = decode_btn(b0, b1);
  assign digit_s    = (ev_s == D1);
  assign bad_s      = (digit_s != code_s[LAST_POS - pos_q]);
  assign fail_inc_s = fail_q + FAIL_W'(1);

  lock_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load_s),
    .value_i  (tmr_val_s),
    .en_i     (tmr_en_s),
    .expire_o (tmr_expire_s)
  );

  // Next-state, timer control and next registered outputs.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    mis_d      = mis_q;
    fail_d     = fail_q;
    err_d      = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = {TMR_W{1'b0}};
    tmr_en_s   = 1'b0;
`ifdef LOCK_PROGRAM_EN
    code_d     = code_q;
    stage_d    = stage_q;
`endif

    case (state_q)
      ENTRY: begin
        case (ev_s)
          D0, D1: begin
            if (pos_q == LAST_POS) begin
              pos_d = {POS_W{1'b0}};
              mis_d = 1'b0;
              if (!(mis_q || bad_s)) begin
                state_d    = UNLOCKED;
                fail_d     = {FAIL_W{1'b0}};
                tmr_load_s = 1'b1;
                tmr_val_s  = TMR_W'(UNLOCK_CYCLES);
              end else begin
                err_d  = 1'b1;
                fail_d = fail_inc_s;
                if (fail_inc_s == FAIL_MAX) begin
                  state_d    = LOCKOUT;
                  tmr_load_s = 1'b1;
                  tmr_val_s  = TMR_W'(LOCKOUT_CYCLES);
                end else begin
                  state_d = ENTRY;
                end
              end
            end else begin
              pos_d = pos_q + POS_W'(1);
              mis_d = mis_q | bad_s;
            end
          end
          CANCEL: begin
            pos_d = {POS_W{1'b0}};
            mis_d = 1'b0;
          end
          default: begin
            pos_d = pos_q;
          end
        endcase
      end

      UNLOCKED: begin
        tmr_en_s = 1'b1;
        if (tmr_expire_s) begin
          state_d = ENTRY;
`ifdef LOCK_PROGRAM_EN
        end else if (ev_s == CANCEL) begin
          state_d = PROG;
          pos_d   = {POS_W{1'b0}};
          stage_d = {CODE_LEN{1'b0}};
`endif
        end else begin
          state_d = UNLOCKED;
        end
      end

      LOCKOUT: begin
        tmr_en_s = 1'b1;
        if (tmr_expire_s) begin
          state_d = ENTRY;
          fail_d  = {FAIL_W{1'b0}};
        end else begin
          state_d = LOCKOUT;
        end
      end

`ifdef LOCK_PROGRAM_EN
      PROG: begin
        case (ev_s)
          D0, D1: begin
            stage_d = stage_shift_s;
            if (pos_q == LAST_POS) begin
              code_d  = stage_shift_s;
              pos_d   = {POS_W{1'b0}};
              state_d = ENTRY;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end
          CANCEL: begin
            stage_d = {CODE_LEN{1'b0}};
            pos_d   = {POS_W{1'b0}};
            state_d = ENTRY;
          end
          default: begin
            state_d = PROG;
          end
        endcase
      end
`endif

      default: begin
        state_d = ENTRY;
        pos_d   = {POS_W{1'b0}};
        mis_d   = 1'b0;
      end
    endcase

    unlock_d  = (state_d == UNLOCKED) || (state_d == PROG);
    lockout_d = (state_d == LOCKOUT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ENTRY;
      pos_q     <= {POS_W{1'b0}};
      mis_q     <= 1'b0;
      fail_q    <= {FAIL_W{1'b0}};
      err_q     <= 1'b0;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      mis_q     <= mis_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      unlock_q  <= unlock_d;
      lockout_q <= lockout_d;
    end
  end

`ifdef LOCK_PROGRAM_EN
  // Programmable code and its staging register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q  <= DEFAULT_CODE;
      stage_q <= {CODE_LEN{1'b0}};
    end else begin
      code_q  <= code_d;
      stage_q <= stage_d;
    end
  end
`endif

  assign unlock   = unlock_q;
  assign lockout  = lockout_q;
  assign err      = err_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_electronics_lock_gen.sv
// Directed self-checking bench for electronics_lock_gen (default parameters).
module tb_electronics_lock_gen;

  logic       clk;
  logic       reset;
  logic       b0;
  logic       b1;
  logic       unlock;
  logic       lockout;
  logic       err;
  logic [1:0] fail_cnt;

  int n_tests;
  int n_fail;

  electronics_lock_gen dut (
    .clk      (clk),
    .reset    (reset),
    .b0       (b0),
    .b1       (b1),
    .unlock   (unlock),
    .lockout  (lockout),
    .err      (err),
    .fail_cnt (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change at a negedge; the task returns at the next negedge.
  task automatic drive(input logic v0, input logic v1);
    b0 = v0;
    b1 = v1;
    @(negedge clk);
  endtask

  task automatic dig(input logic d);
    drive(~d, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic word(input logic [4:0] w);
    for (int i = 4; i >= 0; i--) dig(w[i]);
  endtask

  // Counts remaining negedges (including the current one) the flag stays high.
  task automatic count_high(input string tag, input int sel, input int exp);
    int cnt;
    cnt = 0;
    while (((sel == 0) ? unlock : lockout) && cnt < 100) begin
      cnt++;
      drive(1'b0, 1'b0);
    end
    check(tag, cnt, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("rst_unlock", unlock, 0);
    check("rst_lockout", lockout, 0);
    check("rst_err", err, 0);
    check("rst_fail", fail_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    b0      = 1'b0;
    b1      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_unlock", unlock, 0);
    check("reset_lockout", lockout, 0);
    check("reset_err", err, 0);
    check("reset_fail", fail_cnt, 0);
    reset = 1'b1;
    idle(1);

    // Correct word opens for exactly 8 cycles.
    word(5'b01011);
    check("t1_unlock", unlock, 1);
    check("t1_err", err, 0);
    check("t1_fail", fail_cnt, 0);
    count_high("t1_hold", 0, 8);
    check("t1_relock", unlock, 0);

    // One wrong word, then the right one clears the counter.
    word(5'b01010);
    check("t2_err", err, 1);
    check("t2_fail", fail_cnt, 1);
    check("t2_unlock", unlock, 0);
    idle(1);
    check("t2_err_pulse", err, 0);
    check("t2_fail_hold", fail_cnt, 1);
    word(5'b01011);
    check("t2_unlock2", unlock, 1);
    check("t2_fail_clr", fail_cnt, 0);
    count_high("t2_hold", 0, 8);

    // Three wrong words trigger a 16-cycle lockout that ignores input.
    word(5'b00000);
    check("t3_fail1", fail_cnt, 1);
    word(5'b11111);
    check("t3_fail2", fail_cnt, 2);
    check("t3_no_lock", lockout, 0);
    word(5'b01001);
    check("t3_lockout", lockout, 1);
    check("t3_err", err, 1);
    check("t3_fail3", fail_cnt, 3);
    word(5'b01011);
    check("t3_ignored", unlock, 0);
    check("t3_still_locked", lockout, 1);
    count_high("t3_lock_hold", 1, 11);
    check("t3_fail_clr", fail_cnt, 0);
    word(5'b01011);
    check("t3_unlock", unlock, 1);
    count_high("t3_hold", 0, 8);

    // Cancel mid-word restarts entry.
    dig(1'b0);
    dig(1'b1);
    drive(1'b1, 1'b1);
    check("t4_cancel_err", err, 0);
    word(5'b01011);
    check("t4_unlock", unlock, 1);
    check("t4_err", err, 0);
    count_high("t4_hold", 0, 8);

    // Reset mid-entry with a failure recorded.
    word(5'b00000);
    check("t4_fail_pre", fail_cnt, 1);
    dig(1'b0);
    dig(1'b1);
    dig(1'b0);
    pulse_reset();
    word(5'b01011);
    check("t4_pos_clr", unlock, 1);
    count_high("t4_hold2", 0, 8);

    // Idle gaps between digits.
    for (int i = 4; i >= 0; i--) begin
      dig(((5'b01011 >> i) & 5'd1) != 5'd0);
      if (i != 0) idle(3);
    end
    check("t5_unlock", unlock, 1);
    count_high("t5_hold", 0, 8);

`ifdef LOCK_PROGRAM_EN
    // Reprogram to 11001 while unlocked.
    word(5'b01011);
    drive(1'b1, 1'b1);
    check("t6_prog_unlock", unlock, 1);
    word(5'b11001);
    check("t6_relock", unlock, 0);
    word(5'b01011);
    check("t6_old_err", err, 1);
    check("t6_old_fail", fail_cnt, 1);
    word(5'b11001);
    check("t6_new_unlock", unlock, 1);
    check("t6_new_fail", fail_cnt, 0);
    count_high("t6_hold", 0, 8);
    pulse_reset();
    word(5'b01011);
    check("t6_default_back", unlock, 1);
    count_high("t6_hold2", 0, 8);
`else
    // Cancel while unlocked is ignored and the code cannot change.
    word(5'b01011);
    drive(1'b1, 1'b1);
    check("t6_cancel_unlock", unlock, 1);
    word(5'b11001);
    check("t6_digits_ignored", unlock, 1);
    count_high("t6_hold_rest", 0, 2);
    word(5'b11001);
    check("t6_code_fixed_err", err, 1);
    check("t6_code_fixed_fail", fail_cnt, 1);
    word(5'b01011);
    check("t6_unlock", unlock, 1);
    count_high("t6_hold", 0, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
